// File: rtl/niosmp_nios2_oci_dct_ctrl_if.sv
// Frame input, session control and readout signals of the debug-trace capture controller.
// The master side drives frames, arm/trig and pops; the slave side is the controller.
interface niosmp_nios2_oci_dct_ctrl_if;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        arm;
    logic        trig;
    logic        rd_req;
    logic [33:0] rd_data;
    logic        rd_valid;
    logic        rd_empty;
    logic        wrap_flag;
    logic [1:0]  state;
    logic [7:0]  drop_count;

    modport master (
        output dct_buffer, dct_count, dct_valid, test_ending, arm, trig, rd_req,
        input  rd_data, rd_valid, rd_empty, wrap_flag, state, drop_count
    );

    modport slave (
        input  dct_buffer, dct_count, dct_valid, test_ending, arm, trig, rd_req,
        output rd_data, rd_valid, rd_empty, wrap_flag, state, drop_count
    );
endinterface

// File: rtl/niosmp_nios2_oci_dct_ctrl.sv
// Debug-trace capture: circular pre-trigger window, POSTTRIG frames after trigger, then FIFO readout.
// Pops return data one cycle after rd_req; no backpressure on frames (overflow overwrites or drops).
module niosmp_nios2_oci_dct_ctrl #(
    parameter int DEPTH    = 16,
    parameter int POSTTRIG = 8
) (
    input logic                         clk,
    input logic                         reset_n,
    niosmp_nios2_oci_dct_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] KEEP = (AW+1)'(DEPTH - POSTTRIG);
    localparam logic [AW:0] PT   = (AW+1)'(POSTTRIG);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, excess;
    logic [AW:0]   level_q, level_d, post_q, post_d;
    logic          wrap_q, wrap_d, rd_valid_q, rd_valid_d, mem_we, frame_ok;
    logic [7:0]    drop_q, drop_d;
    logic [33:0]   rd_data_q, rd_data_d;
    logic [33:0]   mem [DEPTH];

    // Assert asynchronously, release only on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        post_d     = post_q;
        wrap_d     = wrap_q;
        drop_d     = drop_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        excess     = '0;
        frame_ok   = bus.dct_valid && (bus.dct_count != 4'd0);
        case (state_q)
            S_ARMED: begin
                if (frame_ok) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    if (level_q == FULL) begin
                        rptr_d = rptr_q + AW'(1);
                        wrap_d = 1'b1;
                    end else begin
                        level_d = level_q + (AW+1)'(1);
                    end
                end
                if (bus.test_ending) begin
                    state_d = S_DONE;
                end else if (bus.trig) begin
                    state_d = S_POST;
                    // Trim the pre-trigger history so all post-trigger frames fit without overwriting.
                    if (level_d > KEEP) begin
                        excess  = AW'(level_d - KEEP);
                        rptr_d  = rptr_d + excess;
                        level_d = KEEP;
                    end
                end
            end
            S_POST: begin
                if (frame_ok) begin
                    if (level_q == FULL) begin
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    end else begin
                        mem_we  = 1'b1;
                        wptr_d  = wptr_q + AW'(1);
                        level_d = level_q + (AW+1)'(1);
                        post_d  = post_q + (AW+1)'(1);
                    end
                end
                if (bus.test_ending || post_d == PT) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.arm) begin
                    state_d = S_ARMED;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    level_d = '0;
                    post_d  = '0;
                    wrap_d  = 1'b0;
                    drop_d  = '0;
                end else begin
                    if (frame_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    if (bus.rd_req && level_q != '0) begin
                        rd_data_d  = mem[rptr_q];
                        rd_valid_d = 1'b1;
                        rptr_d     = rptr_q + AW'(1);
                        level_d    = level_q - (AW+1)'(1);
                    end
                end
            end
            default: begin
                if (bus.arm) begin
                    state_d = S_ARMED;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    level_d = '0;
                    post_d  = '0;
                    wrap_d  = 1'b0;
                    drop_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            post_q     <= '0;
            wrap_q     <= 1'b0;
            drop_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            post_q     <= post_d;
            wrap_q     <= wrap_d;
            drop_q     <= drop_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q] <= {bus.dct_count, bus.dct_buffer};
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_empty   = (level_q == '0);
    assign bus.wrap_flag  = wrap_q;
    assign bus.state      = state_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_niosmp_nios2_oci_dct_ctrl.sv
// Directed bench for the trace capture controller: queue-based reference model checked every cycle,
// plus hand-computed expectations for the capture, wrap, drop, readout and reset scenarios.
module tb_niosmp_nios2_oci_dct_ctrl;
    localparam int DEPTH    = 16;
    localparam int POSTTRIG = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    niosmp_nios2_oci_dct_ctrl_if bus();

    niosmp_nios2_oci_dct_ctrl #(.DEPTH(DEPTH), .POSTTRIG(POSTTRIG)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: capture window as a queue of {count, buffer} entries.
    logic [33:0] mq[$];
    int          m_state, m_drop, m_post;
    bit          m_wrap, m_rd_valid;
    logic [33:0] m_rd_data;

    task automatic m_clear();
        mq.delete();
        m_wrap = 1'b0;
        m_drop = 0;
        m_post = 0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_clear();
            m_state    = 0;
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
        end else begin
            bit fr;
            logic [33:0] e;
            fr = bus.dct_valid && (bus.dct_count != 0);
            e  = {bus.dct_count, bus.dct_buffer};
            m_rd_valid = 1'b0;
            case (m_state)
                1: begin
                    if (fr) begin
                        if (mq.size() == DEPTH) begin
                            void'(mq.pop_front());
                            m_wrap = 1'b1;
                        end
                        mq.push_back(e);
                    end
                    if (bus.test_ending) m_state = 3;
                    else if (bus.trig) begin
                        while (mq.size() > DEPTH - POSTTRIG) void'(mq.pop_front());
                        m_post  = 0;
                        m_state = 2;
                    end
                end
                2: begin
                    if (fr) begin
                        if (mq.size() == DEPTH) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                        else begin
                            mq.push_back(e);
                            m_post++;
                        end
                    end
                    if (bus.test_ending || m_post == POSTTRIG) m_state = 3;
                end
                3: begin
                    if (bus.arm) begin
                        m_clear();
                        m_state = 1;
                    end else begin
                        if (fr) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                        if (bus.rd_req && mq.size() > 0) begin
                            m_rd_data  = mq.pop_front();
                            m_rd_valid = 1'b1;
                        end
                    end
                end
                default: if (bus.arm) begin
                    m_clear();
                    m_state = 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_state",    bus.state,      m_state);
            check("mdl_rd_valid", bus.rd_valid,   m_rd_valid);
            check("mdl_rd_data",  bus.rd_data,    m_rd_data);
            check("mdl_rd_empty", bus.rd_empty,   mq.size() == 0);
            check("mdl_wrap",     bus.wrap_flag,  m_wrap);
            check("mdl_drop",     bus.drop_count, m_drop);
        end
    end

    task automatic pulse_arm();
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
    endtask

    task automatic pulse_trig();
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
    endtask

    task automatic frame(input int n, input logic [3:0] cnt);
        bus.dct_valid  = 1'b1;
        bus.dct_count  = cnt;
        bus.dct_buffer = 30'(n);
        @(negedge clk);
        bus.dct_valid  = 1'b0;
    endtask

    task automatic pop_check(input int n, input int first, input string nm);
        bus.rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) bus.rd_req = 1'b0;
            check({nm, "_vld"}, bus.rd_valid, 1);
            check(nm, bus.rd_data, {4'd3, 30'(first + i)});
        end
    endtask

    initial begin
        bus.dct_buffer = '0; bus.dct_count = '0; bus.dct_valid = 1'b0;
        bus.test_ending = 1'b0; bus.arm = 1'b0; bus.trig = 1'b0; bus.rd_req = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_state",    bus.state,      0);
        check("rst_rd_empty", bus.rd_empty,   1);
        check("rst_rd_valid", bus.rd_valid,   0);
        check("rst_rd_data",  bus.rd_data,    0);
        check("rst_drop",     bus.drop_count, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (4) @(negedge clk);

        // Ignored controls while idle.
        pulse_trig();
        check("idle_trig_state", bus.state, 0);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("idle_rd_valid", bus.rd_valid, 0);

        // Basic capture: 5 pre, trigger, 8 post.
        pulse_arm();
        check("t1_armed", bus.state, 1);
        for (int i = 1; i <= 5; i++) frame(i, 4'd3);
        pulse_trig();
        check("t1_post", bus.state, 2);
        for (int i = 6; i <= 13; i++) begin
            frame(i, 4'd3);
            if (i == 12) check("t1_still_post", bus.state, 2);
        end
        check("t1_done", bus.state, 3);
        pop_check(13, 1, "t1_pop");
        check("t1_empty", bus.rd_empty, 1);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("t1_rd_at_empty", bus.rd_valid, 0);
        check("t1_rd_hold", bus.rd_data, {4'd3, 30'd13});

        // Wrap: 20 pre-trigger frames, then 8 post.
        pulse_arm();
        check("t2_rearm_empty", bus.rd_empty, 1);
        for (int i = 1; i <= 20; i++) frame(i, 4'd3);
        check("t2_wrap_pre", bus.wrap_flag, 1);
        pulse_trig();
        for (int i = 21; i <= 28; i++) frame(i, 4'd3);
        check("t2_done", bus.state, 3);
        check("t2_wrap", bus.wrap_flag, 1);
        pop_check(16, 13, "t2_pop");
        check("t2_empty", bus.rd_empty, 1);

        // Zero-count frames are neither stored, counted nor dropped.
        pulse_arm();
        check("t3_wrap_clr", bus.wrap_flag, 0);
        for (int i = 1; i <= 3; i++) begin
            frame(i, 4'd5);
            frame(100 + i, 4'd0);
        end
        bus.dct_valid = 1'b0; bus.dct_count = 4'd9;
        @(negedge clk);
        pulse_trig();
        for (int i = 4; i <= 11; i++) begin
            frame(200 + i, 4'd0);
            if (i == 11) check("t3_still_post", bus.state, 2);
            frame(i, 4'(i));
        end
        check("t3_done", bus.state, 3);
        for (int i = 0; i < 4; i++) frame(300 + i, 4'd0);
        check("t3_no_drop", bus.drop_count, 0);
        frame(400, 4'd7);
        frame(401, 4'd7);
        check("t3_drop2", bus.drop_count, 2);

        // test_ending with a frame in ARMED, then saturating drops.
        pulse_arm();
        check("t4_drop_clr", bus.drop_count, 0);
        frame(1, 4'd3);
        frame(2, 4'd3);
        bus.test_ending = 1'b1;
        frame(3, 4'd3);
        bus.test_ending = 1'b0;
        check("t4_done", bus.state, 3);
        check("t4_not_empty", bus.rd_empty, 0);
        for (int i = 0; i < 300; i++) frame(1000 + i, 4'd2);
        check("t4_drop_sat", bus.drop_count, 255);
        pop_check(3, 1, "t4_pop");
        check("t4_empty", bus.rd_empty, 1);

        // Reset in the middle of POST.
        pulse_arm();
        for (int i = 1; i <= 3; i++) frame(50 + i, 4'd3);
        pulse_trig();
        frame(60, 4'd3);
        frame(61, 4'd3);
        check("t5_post", bus.state, 2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_state",    bus.state,      0);
        check("t5_rst_rd_valid", bus.rd_valid,   0);
        check("t5_rst_rd_data",  bus.rd_data,    0);
        check("t5_rst_empty",    bus.rd_empty,   1);
        check("t5_rst_wrap",     bus.wrap_flag,  0);
        check("t5_rst_drop",     bus.drop_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        pulse_arm();
        pulse_trig();
        for (int i = 1; i <= 8; i++) frame(i, 4'd3);
        check("t5_done", bus.state, 3);
        pop_check(8, 1, "t5_pop");
        check("t5_empty", bus.rd_empty, 1);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
